// File: rtl/alu_pkg.sv
// Shared ALU lab definitions: sequencer state encoding, default operand widths
// and the forced quotient returned on divide by zero.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  localparam logic [DW_DEF-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/unsigned_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and report the quotient bit.
module unsigned_divider_div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   prem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   prem_o,
  output logic          qbit_o
);

  // Shifted value carries one spare bit so the compare cannot wrap.
  logic [VW+1:0] shifted;

  always_comb begin
    shifted = {prem_i, bit_i};
    qbit_o  = (shifted >= {2'b00, divisor_i});
    prem_o  = shifted[VW:0];
    if (qbit_o) begin
      prem_o = (VW+1)'(shifted - {2'b00, divisor_i});
    end
  end

endmodule

// File: rtl/unsigned_divider.sv
// Sequential restoring divider, one quotient bit per clock, sharing the
// start/finish handshake of the shift-add multiplier.
module unsigned_divider
  import alu_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [VW-1:0] b,
  output logic          busy,
  output logic          finish,
  output logic [DW-1:0] quotient_out,
  output logic [VW-1:0] remainder_out,
  output logic          div_by_zero
);

  // Handshake: start is a request sampled only in IDLE (busy=0); finish is a
  // single-cycle pulse and the result outputs are valid from that cycle until
  // the next completion or reset.

  localparam int CW = $clog2(DW+1);

  state_t        state_q, state_d;
  logic [DW-1:0] dvd_q, dvd_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [VW:0]   prem_q, prem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dz_q, dz_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic          fin_q, fin_d;

  logic [VW:0]   step_prem;
  logic          step_qbit;

  unsigned_divider_div_step #(.VW(VW)) u_div_step (
    .prem_i    (prem_q),
    .bit_i     (dvd_q[DW-1]),
    .divisor_i (dvs_q),
    .prem_o    (step_prem),
    .qbit_o    (step_qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      fin_q   <= fin_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    fin_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = a;
          dvs_d   = b;
          prem_d  = '0;
          cnt_d   = '0;
          dz_d    = (b == '0);
          state_d = CALC;
        end
      end
      CALC: begin
        // The dividend register doubles as the quotient accumulator.
        prem_d = step_prem;
        dvd_d  = {dvd_q[DW-2:0], step_qbit};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(DW-1)) begin
          state_d = IDLE;
          fin_d   = 1'b1;
          dbz_d   = dz_q;
          if (dz_q) begin
            quot_d = DW'(DZ_QUOTIENT);
            rem_d  = '0;
          end else begin
            quot_d = {dvd_q[DW-2:0], step_qbit};
            rem_d  = step_prem[VW-1:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q == CALC);
  assign finish        = fin_q;
  assign quotient_out  = quot_q;
  assign remainder_out = rem_q;
  assign div_by_zero   = dbz_q;

endmodule

// File: tb/tb_unsigned_divider.sv
// Directed and exhaustive checks of the 8/4 restoring divider: results,
// latency, handshake, divide by zero, ignored start and asynchronous reset.
module tb_unsigned_divider;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [3:0] b;
  logic       busy;
  logic       finish;
  logic [7:0] quotient_out;
  logic [3:0] remainder_out;
  logic       div_by_zero;

  int n_checks;
  int n_fail;

  unsigned_divider dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .finish        (finish),
    .quotient_out  (quotient_out),
    .remainder_out (remainder_out),
    .div_by_zero   (div_by_zero)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: called at a falling edge; issues start and waits for finish.
  // edges counts rising edges from the start edge to the one raising finish.
  // inj > 0 drives a bogus start (a=1, b=1) during that CALC cycle.
  task automatic run_op(input logic [7:0] ta, input logic [3:0] tbv, input int inj,
                        output int edges, output int busy_cyc, output bit done);
    a = ta;
    b = tbv;
    start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;
    busy_cyc = 0;
    done = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 40 && !done; i++) begin
      if (finish) begin
        done = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (i == inj) begin
          start = 1'b1;
          a = 8'h01;
          b = 4'h1;
        end else if (i == inj + 1) begin
          start = 1'b0;
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: finish not seen for a=%h b=%h", ta, tbv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    a = 8'h00;
    b = 4'h0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, finish, quotient_out, remainder_out, div_by_zero} !== 15'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b fin=%b q=%h r=%h dz=%b required all 0",
               busy, finish, quotient_out, remainder_out, div_by_zero);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e, bc;
    bit d;
    run_op(8'h2A, 4'h6, 0, e, bc, d);
    n_checks++;
    if (bc !== 8) begin
      n_fail++;
      $display("FAIL basic_busy: got %0d busy cycles required 8", bc);
    end
    n_checks++;
    if (e !== 9) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d edges required 9", e);
    end
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h07, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: got q=%h r=%h dz=%b required q=07 r=0 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
    n_checks++;
    if ({finish, quotient_out, remainder_out} !== {1'b0, 8'h07, 4'h0}) begin
      n_fail++;
      $display("FAIL basic_hold: got fin=%b q=%h r=%h required fin=0 q=07 r=0",
               finish, quotient_out, remainder_out);
    end
  endtask

  task automatic test_back_to_back();
    int e, bc;
    bit d;
    run_op(8'hE1, 4'hD, 0, e, bc, d);
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h11, 4'h4, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_first: got q=%h r=%h dz=%b required q=11 r=4 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    // Still in the finish cycle: the next start must be accepted.
    run_op(8'h05, 4'h9, 0, e, bc, d);
    n_checks++;
    if (e !== 9) begin
      n_fail++;
      $display("FAIL b2b_latency: got %0d edges required 9", e);
    end
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h00, 4'h5, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_second: got q=%h r=%h dz=%b required q=00 r=5 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    int e, bc;
    bit d;
    run_op(8'h37, 4'h0, 0, e, bc, d);
    n_checks++;
    if (e !== 9) begin
      n_fail++;
      $display("FAIL dz_latency: got %0d edges required 9", e);
    end
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'hFF, 4'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL dz_result: got q=%h r=%h dz=%b required q=ff r=0 dz=1",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
    run_op(8'hFF, 4'hF, 0, e, bc, d);
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h11, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL dz_recover: got q=%h r=%h dz=%b required q=11 r=0 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int e, bc;
    bit d;
    run_op(8'h80, 4'h3, 4, e, bc, d);
    n_checks++;
    if (e !== 9) begin
      n_fail++;
      $display("FAIL ignore_latency: got %0d edges required 9", e);
    end
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h2A, 4'h2, 1'b0}) begin
      n_fail++;
      $display("FAIL ignore_result: got q=%h r=%h dz=%b required q=2a r=2 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int e, bc;
    bit d;
    bit seen_fin;
    a = 8'h64;
    b = 4'h7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, finish, quotient_out, remainder_out, div_by_zero} !== 15'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%b fin=%b q=%h r=%h dz=%b required all 0",
               busy, finish, quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    seen_fin = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (finish || busy) seen_fin = 1'b1;
    end
    n_checks++;
    if (seen_fin !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_nofinish: got activity=%b required 0", seen_fin);
    end
    run_op(8'h64, 4'h7, 0, e, bc, d);
    n_checks++;
    if ({quotient_out, remainder_out, div_by_zero} !== {8'h0E, 4'h2, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_rerun: got q=%h r=%h dz=%b required q=0e r=2 dz=0",
               quotient_out, remainder_out, div_by_zero);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int e, bc;
    bit d;
    int recon;
    for (int ia = 0; ia < 256; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        run_op(8'(ia), 4'(ib), 0, e, bc, d);
        n_checks++;
        if (e !== 9) begin
          n_fail++;
          $display("FAIL sweep_latency a=%h b=%h: got %0d edges required 9", ia, ib, e);
        end
        n_checks++;
        if (ib == 0) begin
          if ({quotient_out, remainder_out, div_by_zero} !== {8'hFF, 4'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL sweep_dz a=%h: got q=%h r=%h dz=%b required q=ff r=0 dz=1",
                     ia, quotient_out, remainder_out, div_by_zero);
          end
        end else begin
          recon = int'(quotient_out) * ib + int'(remainder_out);
          if (recon != ia || int'(remainder_out) >= ib || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_div a=%h b=%h: got q=%h r=%h dz=%b required q=%h r=%h dz=0",
                     ia, ib, quotient_out, remainder_out, div_by_zero, ia / ib, ia % ib);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_by_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
